// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: level/edge trigger capture, claim/complete handshake, saturating edge counter.
// Optional PLIC_GATEWAY_SYNC_EN inserts a 2-flop synchronizer on src_i ahead of the trigger logic.
module plic_gateway #(
  parameter int N_SOURCE = 128,
  parameter int MAX_EDGE = 3,
  parameter int CNTW     = $clog2(MAX_EDGE + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE:0]   claim_i,
  input  logic [N_SOURCE:0]   complete_i,
  output logic [N_SOURCE:0]   ip_o,
  output logic [N_SOURCE:0]   sv_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_e;

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_EDGE);

  function automatic logic [CNTW-1:0] sat_cnt(input logic [CNTW-1:0] cnt,
                                              input logic inc, input logic dec);
    logic [CNTW:0] sum;
    sum = {1'b0, cnt} + {{CNTW{1'b0}}, inc};
    if (dec && (sum != '0)) sum = sum - 1'b1;
    if (sum > {1'b0, CNT_MAX}) return CNT_MAX;
    return sum[CNTW-1:0];
  endfunction

  logic [N_SOURCE-1:0] src_s;
  logic [N_SOURCE-1:0] src_q;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [N_SOURCE-1:0] sync_a, sync_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= src_i;
      sync_b <= sync_a;
    end
  end

  assign src_s = sync_b;
`else
  assign src_s = src_i;
`endif

  // src_q holds the previous sample for rising-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) src_q <= '0;
    else         src_q <= src_s;
  end

  for (genvar i = 1; i <= N_SOURCE; i++) begin : g_src
    state_e          state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic            lvl, edge_det, req, idle, cnt_nz;

    always_comb begin
      lvl        = src_s[i-1];
      edge_det   = lvl & ~src_q[i-1];
      idle       = (state == IDLE);
      cnt_nz     = (cnt != '0);
      req        = le_i[i-1] ? (cnt_nz | edge_det) : lvl;
      state_next = state;
      cnt_next   = '0;
      case (state)
        IDLE:    if (req)           state_next = PEND;
        PEND:    if (claim_i[i])    state_next = SERV;
        SERV:    if (complete_i[i]) state_next = IDLE;
        default:                    state_next = IDLE;
      endcase
      // an edge is banked unless it is consumed directly by an empty, idle source
      if (le_i[i-1])
        cnt_next = sat_cnt(cnt, edge_det & (~idle | cnt_nz), idle & req & cnt_nz);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    assign ip_o[i] = (state == PEND);
    assign sv_o[i] = (state == SERV);
  end

  assign ip_o[0] = 1'b0;
  assign sv_o[0] = 1'b0;

  logic unused_bit0;
  assign unused_bit0 = claim_i[0] ^ complete_i[0];

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
Per-source interrupt gateway that sits directly upstream of the PLIC register map.
- Converts raw level- or edge-triggered device interrupt lines into the pending vector `ip_o`, which feeds the register map's `ip_i`.
- Consumes decoded claim and complete events, so each source can have at most one request outstanding.
- Edge-mode sources have a saturating counter so edges that arrive while a request is outstanding are not lost.

Parameters:
- N_SOURCE, 128, number of interrupt sources; source 0 is reserved.
- MAX_EDGE, 3, saturation value of the per-source pending-edge counter; must be at least 1.
- CNTW, $clog2(MAX_EDGE+1), edge counter width; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- src_i  in  N_SOURCE  raw interrupt lines; bit i-1 is source i
- le_i  in  N_SOURCE  trigger mode per source; 1 = rising edge, 0 = level-high
- claim_i  in  N_SOURCE+1  one-hot-per-source claim pulse, OR of all targets' claim decodes; bit 0 ignored
- complete_i  in  N_SOURCE+1  completion pulse, same indexing; bit 0 ignored
- ip_o  out  N_SOURCE+1  pending vector to the register map; bit 0 tied to 0
- sv_o  out  N_SOURCE+1  in-service vector for debug/readback; bit 0 tied to 0

Behaviour:
- Reset is asynchronous, active-low, single clock domain: clk_i, rst_ni.
- At reset, per source:
  - state = IDLE
  - counter = 0
  - src_q = 0
  - ip_o = 0 and sv_o = 0
- Each source is independent. Per-source FSM:
  - IDLE: ip=0, sv=0.
  - PEND: ip=1, sv=0.
  - SERV: ip=0, sv=1.
- ip_o and sv_o are registered and decoded from state only.
- Trigger request `req`:
  - Level mode: req = src_i.
  - Edge mode: edge = src_i & ~src_q, where src_q is src_i delayed one cycle; req = (cnt != 0) | edge.
- FSM transitions:
  - IDLE & req -> PEND.
  - PEND & claim -> SERV.
  - SERV & complete -> IDLE.
  - All other combinations hold state.
- Latency:
  - src_i first sampled high (level) or rising (edge) at clock edge k -> ip_o=1 after edge k.
  - Claim at edge k -> ip_o=0, sv_o=1 after edge k.
  - SERV -> IDLE -> PEND re-raise takes a minimum of 2 edges after complete.
- Level mode:
  - The request is latched: src_i dropping while in PEND does not clear ip.
  - cnt is forced to 0 whenever le_i=0.
- Edge counter (edge mode), computed as cnt_next = sat(cnt + inc - dec):
  - inc = edge occurring while not consumed directly, i.e. state != IDLE, or state == IDLE with cnt != 0.
  - dec = IDLE->PEND transition while cnt != 0.
  - Saturates at MAX_EDGE; further edges are dropped silently.
  - Never underflows.
- Simultaneous events:
  - Edge in IDLE with cnt=0: consumed directly; cnt stays 0.
  - Claim and complete in the same cycle: only the one valid for the current state acts (claim in PEND, complete in SERV).
- Stray events:
  - Claim in IDLE or SERV is ignored.
  - Complete in IDLE or PEND is ignored; it must not corrupt cnt.
- Mode change: an le_i change takes effect on the next cycle. Switching to level clears cnt. FSM state is preserved.
- Reset mid-operation: everything returns to reset values immediately; pending edges are discarded.

Optional Feature:
- Macro: PLIC_GATEWAY_SYNC_EN.
- Defined:
  - src_i passes through a 2-flop synchronizer (reset 0) before trigger logic.
  - All src-to-ip latencies grow by 2 cycles.
  - Edge detection operates on the synchronized signal.
- Undefined: src_i is used directly and must be synchronous to clk_i.

Test Plan:
- Level, source 5:
  - Stimulus: src_i[4]=1 at edge 10 -> ip_o[5]=1 after edge 10; drop src at edge 12 -> ip_o[5] stays 1.
  - Stimulus: claim_i[5] at edge 14 -> ip_o[5]=0, sv_o[5]=1.
  - Stimulus: complete_i[5] at edge 16 -> IDLE; no re-raise, since src is low.
- Edge, source 3, MAX_EDGE=3:
  - Stimulus: 5 rising edges while in SERV -> cnt saturates at 3.
  - Stimulus: then 3 claim/complete rounds -> ip_o[3] re-raises exactly 3 times, then stays 0.
- Edge in IDLE with cnt=0 -> PEND with cnt remaining 0. Edge in the same cycle as an IDLE->PEND consume with cnt=2 -> cnt stays 2.
- Stray pulses, none changing state, ip_o or cnt:
  - complete_i[7] while source 7 is PEND.
  - claim_i[7] while IDLE.
  - claim_i[0] at any time.
- Reset asserted asynchronously while sources 1..4 are in PEND/SERV with cnt=2 -> all outputs go 0 before the next edge; cnt=0 after release.
- With PLIC_GATEWAY_SYNC_EN: level assert sampled at edge k -> ip_o=1 after edge k+2.
